// File: rtl/rr_merge_pkg.sv
// Shared types and constants for the four-port round-robin packet merger.
package rr_merge_pkg;

  localparam int NUM_PORTS = 4;
  localparam int PORT_ID_W = 2;

  typedef enum logic {IDLE, BUSY} merge_state_t;
  typedef logic [PORT_ID_W-1:0] port_id_t;

  function automatic logic [NUM_PORTS-1:0] id_to_onehot(input port_id_t id);
    id_to_onehot = NUM_PORTS'(1) << id;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod 4.
module rr_pick4
  import rr_merge_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_id_t             ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output port_id_t             gnt_id,
  output logic                 any
);

  port_id_t idx;

  always_comb begin
    gnt    = '0;
    gnt_id = ptr;
    any    = 1'b0;
    idx    = ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = ptr + port_id_t'(k);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_merge_arbiter.sv
// Four-to-one packet merger with packet-granular round-robin arbitration and a
// single registered output stage tagged with the source port id.
module rr_merge_arbiter
  import rr_merge_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic [NUM_PORTS-1:0]  din_valid,
  input  logic [NUM_PORTS-1:0]  din_last,
  output logic [NUM_PORTS-1:0]  din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [PORT_ID_W-1:0]  dout_addr,
  output logic                  dout_last,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  merge_state_t          state_q, state_d;
  port_id_t              owner_q, owner_d;
  port_id_t              rr_ptr_q, rr_ptr_d;
  port_id_t              dout_addr_q, dout_addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_last_q, dout_last_d;
  logic                  dout_valid_q, dout_valid_d;

  logic [NUM_PORTS-1:0]  pick_gnt, gnt;
  port_id_t              pick_id, gnt_id;
  logic                  pick_any, load, xfer, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_pick4 u_pick (
    .req    (din_valid),
    .ptr    (rr_ptr_q),
    .gnt    (pick_gnt),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // While a packet is open only its owner may be granted, even if it is idle.
  assign load      = !dout_valid_q || dout_ready;
  assign gnt       = (state_q == BUSY) ? id_to_onehot(owner_q) : pick_gnt;
  assign gnt_id    = (state_q == BUSY) ? owner_q : pick_id;
  assign din_ready = (resetn && load) ? gnt : '0;
  assign xfer      = load && ((state_q == BUSY) ? din_valid[owner_q] : pick_any);
  assign sel_last  = din_last[gnt_id];

  always_comb begin
    sel_data = din0;
    case (gnt_id)
      2'd0: sel_data = din0;
      2'd1: sel_data = din1;
      2'd2: sel_data = din2;
      2'd3: sel_data = din3;
      default: sel_data = din0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    dout_d       = dout_q;
    dout_addr_d  = dout_addr_q;
    dout_last_d  = dout_last_q;
    dout_valid_d = dout_valid_q;

    if (load) begin
      dout_valid_d = xfer;
      if (xfer) begin
        dout_d      = sel_data;
        dout_addr_d = gnt_id;
        dout_last_d = sel_last;
      end
    end

    // The priority pointer only advances at packet boundaries.
    if (xfer) begin
      if (sel_last) begin
        state_d  = IDLE;
        rr_ptr_d = gnt_id + port_id_t'(1);
      end else begin
        state_d = BUSY;
        owner_d = gnt_id;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      dout_q       <= '0;
      dout_addr_q  <= '0;
      dout_last_q  <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      dout_q       <= dout_d;
      dout_addr_q  <= dout_addr_d;
      dout_last_q  <= dout_last_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_addr  = dout_addr_q;
  assign dout_last  = dout_last_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_rr_merge_arbiter.sv
// Bench for rr_merge_arbiter: per-cycle vectors with hand-derived grants and a
// scoreboard of accepted beats that must emerge in order on the output.
module tb_rr_merge_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] din0, din1, din2, din3;
  logic [3:0]    din_valid, din_last, din_ready;
  logic [DW-1:0] dout;
  logic [1:0]    dout_addr;
  logic          dout_last, dout_valid, dout_ready;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    addr;
    logic          last;
  } beat_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       dready;
    logic [3:0] expReady;
  } vec_t;

  beat_t sb[$];
  vec_t  vecs[24];
  int    compared   = 0;
  int    mismatched = 0;

  rr_merge_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din0       (din0),
    .din1       (din1),
    .din2       (din2),
    .din3       (din3),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_addr  (dout_addr),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check outputs shortly after, then book accepted beats.
  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic dr,
                               input logic [3:0] er, input logic [15:0] tag);
    beat_t head;
    @(negedge clk);
    din_valid  = v;
    din_last   = l;
    dout_ready = dr;
    din0 = {tag, 16'h0000};
    din1 = {tag, 16'h0001};
    din2 = {tag, 16'h0002};
    din3 = {tag, 16'h0003};
    #1;
    checkOutput("din_ready", 32'(din_ready), 32'(er));
    checkOutput("dout_valid", 32'(dout_valid), 32'(sb.size() != 0));
    if (dout_valid && sb.size() != 0) begin
      head = sb[0];
      checkOutput("dout", dout, head.data);
      checkOutput("dout_addr", 32'(dout_addr), 32'(head.addr));
      checkOutput("dout_last", 32'(dout_last), 32'(head.last));
      if (dr) void'(sb.pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      if (v[i] && er[i]) sb.push_back('{data: {tag, 16'(i)}, addr: 2'(i), last: l[i]});
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    resetn     = 1'b0;
    din_valid  = 4'hF;
    din_last   = 4'hF;
    dout_ready = 1'b1;
    #1;
    checkOutput("reset dout", dout, 32'h0);
    checkOutput("reset dout_addr", 32'(dout_addr), 32'h0);
    checkOutput("reset dout_last", 32'(dout_last), 32'h0);
    checkOutput("reset dout_valid", 32'(dout_valid), 32'h0);
    checkOutput("reset din_ready", 32'(din_ready), 32'h0);
    sb.delete();
    @(negedge clk);
    din_valid = 4'h0;
    din_last  = 4'h0;
    resetn    = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; din0 = '0; din1 = '0; din2 = '0; din3 = '0;
    din_valid = '0; din_last = '0; dout_ready = 1'b0;

    // Round-robin order, multi-beat lock, backpressure and owner bubbles.
    vecs[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001};
    vecs[5]  = '{4'b0011, 4'b0000, 1'b1, 4'b0010};
    vecs[6]  = '{4'b0011, 4'b0000, 1'b1, 4'b0010};
    vecs[7]  = '{4'b0011, 4'b0010, 1'b1, 4'b0010};
    vecs[8]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001};
    vecs[9]  = '{4'b0100, 4'b0000, 1'b0, 4'b0000};
    vecs[10] = '{4'b0100, 4'b0000, 1'b0, 4'b0000};
    vecs[11] = '{4'b0100, 4'b0000, 1'b0, 4'b0000};
    vecs[12] = '{4'b0100, 4'b0000, 1'b0, 4'b0000};
    vecs[13] = '{4'b0100, 4'b0000, 1'b0, 4'b0000};
    vecs[14] = '{4'b0100, 4'b0000, 1'b1, 4'b0100};
    vecs[15] = '{4'b0100, 4'b0100, 1'b1, 4'b0100};
    vecs[16] = '{4'b0000, 4'b0000, 1'b0, 4'b0000};
    vecs[17] = '{4'b0000, 4'b0000, 1'b1, 4'b0000};
    vecs[18] = '{4'b1001, 4'b0000, 1'b1, 4'b1000};
    vecs[19] = '{4'b0001, 4'b0000, 1'b1, 4'b1000};
    vecs[20] = '{4'b0001, 4'b0000, 1'b1, 4'b1000};
    vecs[21] = '{4'b1001, 4'b1000, 1'b1, 4'b1000};
    vecs[22] = '{4'b0001, 4'b0001, 1'b1, 4'b0001};
    vecs[23] = '{4'b0000, 4'b0000, 1'b1, 4'b0000};

    $display("[TB] single beat from port 2 after reset");
    doReset();
    applyStimulus(4'b0100, 4'b0100, 1'b1, 4'b0100, 16'hA5A5);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000, 16'h0000);
    applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b1000, 16'hB000);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000, 16'h0000);

    $display("[TB] vector table");
    doReset();
    for (int k = 0; k < 24; k++) begin
      applyStimulus(vecs[k].valid, vecs[k].last, vecs[k].dready, vecs[k].expReady,
                    16'h1000 + 16'(k));
    end

    $display("[TB] reset in the middle of a packet");
    applyStimulus(4'b0010, 4'b0000, 1'b1, 4'b0010, 16'hC001);
    @(negedge clk);
    din_valid = 4'b0101;
    din_last  = 4'b0101;
    #1;
    checkOutput("pre-reset dout_valid", 32'(dout_valid), 32'h1);
    resetn = 1'b0;
    #1;
    checkOutput("async reset dout_valid", 32'(dout_valid), 32'h0);
    checkOutput("async reset din_ready", 32'(din_ready), 32'h0);
    checkOutput("async reset dout", dout, 32'h0);
    checkOutput("async reset dout_addr", 32'(dout_addr), 32'h0);
    sb.delete();
    @(negedge clk);
    din_valid = 4'b0000;
    resetn    = 1'b1;
    applyStimulus(4'b0101, 4'b0101, 1'b1, 4'b0001, 16'hD000);
    applyStimulus(4'b0100, 4'b0100, 1'b1, 4'b0100, 16'hD001);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000, 16'h0000);

    checkOutput("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
